// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, one-hot helper
// and the byte width shared with the transmitter.
package uart_arb_pkg;

    localparam int UART_N_BITS = 8;
    localparam int MAX_REQ     = 8;

    localparam logic [2:0] IDLE   = 3'b001;
    localparam logic [2:0] LAUNCH = 3'b010;
    localparam logic [2:0] WAIT   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_LAUNCH = LAUNCH,
        S_WAIT   = WAIT
    } arb_state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit scanning from ptr upward,
// wrapping modulo N_REQ.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        idx    = '0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + 32'(i)) % 32'(N_REQ));
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Optional burst locking is compiled in with `define UART_TX_ARB_LOCK_EN.
//
// state  | meaning
// IDLE   | no owner; arbitrate among pending requests
// LAUNCH | winner latched; one-cycle start strobe to the transmitter
// WAIT   | frame on the line; ack the owner on the done tick
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_BITS    = UART_N_BITS,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*N_BITS-1:0] i_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        i_lock,
`endif
    output logic [N_REQ-1:0]        o_ack,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy,
    output logic                    o_tx_start,
    output logic [N_BITS-1:0]       o_tx_data,
    input  logic                    i_tx_done_tick
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be in 2..8");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("uart_tx_arbiter: MAX_BURST must be at least 1");
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(N_REQ-1)) ? '0 : idx + PTR_W'(1);
    endfunction

    arb_state_e       state, state_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic [PTR_W-1:0] owner, owner_next;
    logic [N_REQ-1:0] grant_next;
    logic [N_BITS-1:0] data_next;
    logic [N_BITS-1:0] win_data;
    logic [N_REQ-1:0] pick_req;
    logic [PTR_W-1:0] pick_ptr;
    logic [PTR_W-1:0] pick_winner;
    logic             pick_valid;

`ifdef UART_TX_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    logic [CNT_W-1:0] burst_cnt, cnt_next;
    logic             locked, locked_next;
    logic             lock_release;

    // While locked only the previous owner (held in ptr) may win.
    assign lock_release = locked && !i_lock[ptr];
    assign pick_ptr     = lock_release ? next_ptr(ptr) : ptr;
    assign pick_req     = (locked && i_lock[ptr]) ? (i_req & N_REQ'(onehot(32'(ptr)))) : i_req;
`else
    assign pick_ptr = ptr;
    assign pick_req = i_req;
`endif

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_winner == PTR_W'(k)) begin
                win_data = i_data[k*N_BITS +: N_BITS];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            o_grant   <= '0;
            o_tx_data <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            burst_cnt <= '0;
            locked    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            o_grant   <= grant_next;
            o_tx_data <= data_next;
`ifdef UART_TX_ARB_LOCK_EN
            burst_cnt <= cnt_next;
            locked    <= locked_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        grant_next = o_grant;
        data_next  = o_tx_data;
        o_ack      = '0;
        o_tx_start = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        cnt_next    = burst_cnt;
        locked_next = locked;
`endif
        case (state)
            S_IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                if (lock_release) begin
                    ptr_next    = pick_ptr;
                    locked_next = 1'b0;
                    cnt_next    = '0;
                end
`endif
                if (pick_valid) begin
                    owner_next = pick_winner;
                    grant_next = N_REQ'(onehot(32'(pick_winner)));
                    data_next  = win_data;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                o_tx_start = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done_tick) begin
                    o_ack      = o_grant;
                    grant_next = '0;
                    state_next = S_IDLE;
                    ptr_next   = next_ptr(owner);
`ifdef UART_TX_ARB_LOCK_EN
                    if (i_lock[owner] && burst_cnt < CNT_W'(MAX_BURST-1)) begin
                        ptr_next    = owner;
                        cnt_next    = burst_cnt + CNT_W'(1);
                        locked_next = 1'b1;
                    end else begin
                        cnt_next    = '0;
                        locked_next = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter; the bench plays the requesters
// and the transmitter, and predicts grants/acks from the round-robin rules.
module tb_uart_tx_arbiter;

    localparam int N_REQ  = 4;
    localparam int N_BITS = 8;
    localparam int NCYC   = 5000;

    logic                    i_clock = 1'b0;
    logic                    i_reset = 1'b1;
    logic [N_REQ-1:0]        i_req = '0;
    logic [N_REQ*N_BITS-1:0] i_data = '0;
    logic                    i_tx_done_tick = 1'b0;
    logic [N_REQ-1:0]        o_ack;
    logic [N_REQ-1:0]        o_grant;
    logic                    o_busy;
    logic                    o_tx_start;
    logic [N_BITS-1:0]       o_tx_data;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N_REQ-1:0]        i_lock = '0;
`endif

    uart_tx_arbiter #(.N_BITS(N_BITS), .N_REQ(N_REQ)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_data         (i_data),
`ifdef UART_TX_ARB_LOCK_EN
        .i_lock         (i_lock),
`endif
        .o_ack          (o_ack),
        .o_grant        (o_grant),
        .o_busy         (o_busy),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .i_tx_done_tick (i_tx_done_tick)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int idx;
        int data;
        int cyc;
    } exp_t;

    exp_t grant_q[$];
    exp_t ack_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    bit               exp_busy;
    bit               exp_rst_now;
    logic [N_REQ-1:0] exp_grant;
    logic [N_BITS-1:0] exp_data;

    // reference model state
    int               p;
    int               w;
    int               launch_cyc;
    int               done_cyc;
    int               den;
    int               rst_done;
    bit               model_idle;
    bit               prev_rst;
    bit               do_rst;
    bit [N_REQ-1:0]   owed;
    bit [N_REQ-1:0]   req_on;
    logic [N_BITS-1:0] dat[N_REQ];
    logic [N_BITS-1:0] cur_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    // monitor: compares DUT outputs at the falling edge against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clock);
            if (mon_en) begin
                if (exp_rst_now) begin
                    check("rst_tx_data", 32'(o_tx_data), 0);
                    check("rst_tx_start", 32'(o_tx_start), 0);
                    check("rst_ack", 32'(o_ack), 0);
                end
                check("busy", 32'(o_busy), 32'(exp_busy));
                check("grant", 32'(o_grant), 32'(exp_grant));
                if (exp_busy) check("tx_data_hold", 32'(o_tx_data), 32'(exp_data));

                if (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
                    e = grant_q.pop_front();
                    check("tx_start_missing", 32'(cyc), 32'(e.cyc));
                end
                if (o_tx_start) begin
                    if (grant_q.size() == 0) begin
                        check("tx_start_spurious", 32'(o_tx_start), 0);
                    end else begin
                        e = grant_q.pop_front();
                        check("tx_start_cycle", 32'(cyc), 32'(e.cyc));
                        check("launch_grant", 32'(o_grant), 32'(1) << e.idx);
                        check("launch_data", 32'(o_tx_data), 32'(e.data));
                    end
                end

                if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                    e = ack_q.pop_front();
                    check("ack_missing", 32'(cyc), 32'(e.cyc));
                end
                if (o_ack != '0) begin
                    if (ack_q.size() == 0) begin
                        check("ack_spurious", 32'(o_ack), 0);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack_cycle", 32'(cyc), 32'(e.cyc));
                        check("ack_value", 32'(o_ack), 32'(1) << e.idx);
                    end
                end
            end
        end
    end

    // driver and reference model: one iteration per clock cycle
    initial begin
        p = 0; w = 0; launch_cyc = 0; done_cyc = 0; rst_done = 0;
        model_idle = 1; prev_rst = 1; owed = '0; req_on = '0; cur_data = '0;
        for (int k = 0; k < N_REQ; k++) dat[k] = '0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge i_clock);
            #1;
            cyc         = c;
            exp_rst_now = prev_rst;
            exp_busy    = !model_idle;
            exp_grant   = model_idle ? '0 : N_REQ'(1 << w);
            exp_data    = cur_data;
            mon_en      = 1;
            i_tx_done_tick = 1'b0;

            if (c < 1500)            den = 4;
            else if (c < 3000)       den = 1;
            else if (c < NCYC - 60)  den = 9;
            else                     den = 0;

            do_rst = (c < 3) ||
                     (!model_idle && c > launch_cyc && c < done_cyc &&
                      ((c >= 1000 && rst_done == 0) || (c >= 2500 && rst_done == 1)));

            if (do_rst) begin
                i_reset = 1'b1;
                if (c >= 3) rst_done++;
                req_on = '0;
                owed   = '0;
                p      = 0;
                model_idle = 1;
                grant_q.delete();
                ack_q.delete();
            end else begin
                i_reset = 1'b0;
                for (int k = 0; k < N_REQ; k++) begin
                    if (!owed[k]) begin
                        if (den != 0 && $urandom_range(den - 1, 0) == 0) begin
                            req_on[k] = 1'b1;
                            owed[k]   = 1'b1;
                            dat[k]    = N_BITS'($urandom);
                        end else begin
                            req_on[k] = 1'b0;
                        end
                    end
                end

                if (model_idle) begin
                    if (req_on != '0) begin
                        for (int i = 0; i < N_REQ; i++) begin
                            if (req_on[(p + i) % N_REQ]) begin
                                w = (p + i) % N_REQ;
                                break;
                            end
                        end
                        cur_data = dat[w];
                        grant_q.push_back('{w, int'(dat[w]), c + 1});
                        launch_cyc = c + 1;
                        done_cyc   = c + 2 + int'($urandom_range(12, 0));
                        model_idle = 0;
                    end
                    if ($urandom_range(5, 0) == 0) i_tx_done_tick = 1'b1;
                end else if (c == launch_cyc) begin
                    dat[w] = N_BITS'($urandom);
                    if ($urandom_range(3, 0) == 0) req_on[w] = 1'b0;
                    if ($urandom_range(2, 0) == 0) i_tx_done_tick = 1'b1;
                end else if (c == done_cyc) begin
                    i_tx_done_tick = 1'b1;
                    ack_q.push_back('{w, 0, c});
                    owed[w]    = 1'b0;
                    p          = (w + 1) % N_REQ;
                    model_idle = 1;
                end
            end
            prev_rst = do_rst;

            i_req = req_on;
            for (int k = 0; k < N_REQ; k++) i_data[k*N_BITS +: N_BITS] = dat[k];
        end

        @(negedge i_clock);
        #1;
        mon_en = 0;
        check("model_drained", 32'(model_idle), 1);
        check("grant_q_empty", 32'(grant_q.size()), 0);
        check("ack_q_empty", 32'(ack_q.size()), 0);
        check("reset_events", 32'(rst_done), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmisor among N_REQ byte producers, such as the ALU result path, a status reporter and a debug echo. Arbitration is round-robin. The block latches the winning byte, pulses the transmitter start strobe for one cycle, waits for the transmitter's done tick, then acknowledges the winner. It sits between the requesters and the transmitter's i_ready/i_din/o_tx_done_tick ports.

Parameters:
N_BITS, 8, byte width; must match the transmitter.
N_REQ, 4, number of requesters, legal range 2..8.
MAX_BURST, 4, maximum consecutive bytes per lock; used only when the optional feature is compiled in.

Ports:
i_clock  in  1  system clock; everything is on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_req  in  N_REQ  level request, one bit per requester.
i_data  in  N_REQ*N_BITS  flat data bus; requester k uses bits [k*N_BITS +: N_BITS].
o_ack  out  N_REQ  one-hot, one-cycle pulse when the granted byte has finished on the line.
o_grant  out  N_REQ  one-hot current owner; all zeros when idle.
o_busy  out  1  high whenever state is not IDLE.
o_tx_start  out  1  to the transmitter's i_ready; one-cycle pulse.
o_tx_data  out  N_BITS  to the transmitter's i_din; registered.
i_tx_done_tick  in  1  from the transmitter's o_tx_done_tick.

Behaviour:
- Reset values: state=IDLE, pointer p=0, o_grant=0, o_tx_data=0, o_tx_start=0, o_ack=0, o_busy=0. Reset mid-transfer aborts immediately. No ack is issued for the aborted byte. The transmitter shares the same reset.
- The FSM is one-hot with three states: IDLE=3'b001, LAUNCH=3'b010, WAIT=3'b100.
- IDLE
  - If i_req is nonzero, pick the winner g: the first set bit scanning p, p+1, …, N_REQ-1, 0, … (modulo N_REQ).
  - At the clock edge: o_grant<=onehot(g), o_tx_data<=i_data slice g, state<=LAUNCH.
  - If i_req is zero, stay in IDLE.
- LAUNCH
  - o_tx_start=1 for exactly this one cycle (decoded from the state register).
  - Next state is WAIT.
- WAIT
  - Hold o_grant and o_tx_data stable.
  - On i_tx_done_tick: o_ack[g]=1 in that same cycle (combinational from the state register and the registered done tick), p<=(g+1) mod N_REQ, state<=IDLE, o_grant<=0.
- Latency
  - Request seen in IDLE at cycle t gives o_tx_start at t+1.
  - The line then carries one frame; the done tick arrives at cycle d and o_ack is high at d.
  - The earliest next grant is at d+1.
- Requester contract
  - Keep i_req high until o_ack.
  - Data is captured at grant and may change afterwards.
  - Dropping i_req after grant does not cancel the transfer; the ack is still pulsed.
  - A requester with another byte keeps i_req high and presents the new data by d+1. It is then re-arbitrated behind the others, because p has moved past it.
- A done tick in IDLE or LAUNCH is ignored: no ack, no state change.
- Fairness: with all requests continuously high, grant order is p, p+1, …, with wrap-around. No requester waits more than N_REQ-1 frames.

Optional Feature:
Macro UART_TX_ARB_LOCK_EN.
- When defined, add input i_lock [N_REQ-1:0] and an internal burst counter, with width clog2(MAX_BURST)+1.
- At the done tick, if i_lock[g]=1 and the count is below MAX_BURST-1:
  - p is not advanced and the count increments.
  - The next IDLE considers only requester g; it waits in IDLE while i_req[g]=0 and i_lock[g]=1.
- If the lock drops, or the count reaches MAX_BURST-1:
  - Normal rules resume and the count is cleared.
  - p advances to g+1.
- When the macro is undefined, there is no i_lock port and behaviour is as described above.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding localparams IDLE, LAUNCH and WAIT;
  - a function returning the onehot of an index;
  - the default N_BITS constant shared with the transmitter.
- Natural sub-module: rr_priority_picker, purely combinational, taking i_req and p and returning winner index and valid.

Test Plan:
1. N_REQ=4; i_req=0001, data0=0x5A, with a real transmitter → o_grant=0001 at t+1, o_tx_start high at t+1 only, o_tx_data=0x5A, line shows 0x5A. At the done tick: o_ack=0001 for one cycle, then o_grant=0.
2. i_req=1111 held, each requester holding its data → grant sequence 0,1,2,3,0,1, one ack per frame in that order.
3. After requester 3 is served, p=0 (wrapped); assert only i_req[2] → granted 2, and p becomes 3 afterwards.
4. i_req[1] rises in the same cycle as the done tick for requester 0 → o_tx_start for 1 at d+2; no second grant to 0 after it drops its request.
5. Assert i_reset during WAIT → next cycle all outputs are zero and p=0; no ack ever appears for that byte; a later request is granted normally.
6. With UART_TX_ARB_LOCK_EN and MAX_BURST=2: i_req=0011, i_lock=0001 → grant order 0,0,1,0,0,1. Then with i_lock=0 → order 0,1,0,1.
